// File: rtl/dram_bus_arbiter_pkg.sv
// dram_bus_arbiter_pkg: shared owner/state encoding and default widths
package dram_bus_arbiter_pkg;
  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_GNT0 = 2'b01,
    ST_GNT1 = 2'b10
  } state_t;
endpackage

// File: rtl/dram_bus_arbiter_if.sv
// dram_bus_arbiter_if: one master's single-beat req/ack channel
// master: drives req/we/lock/addr/wdata, receives ack/rdata; slave: the arbiter side
interface dram_bus_arbiter_if
  import dram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              req;
  logic              we;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  modport master(output req, we, lock, addr, wdata, input ack, rdata);
  modport slave(input req, we, lock, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dram_bus_arbiter_rr_arb2.sv
// dram_bus_arbiter_rr_arb2: next owner / round-robin pointer / hold count for two masters
// in: req, lock (bit 0 = m0), state, rr_ptr, hold_cnt; out: nxt_state, nxt_ptr, nxt_hold
module dram_bus_arbiter_rr_arb2
  import dram_bus_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic [1:0]        req,
  input  logic [1:0]        lock,
  input  state_t            state,
  input  logic              rr_ptr,
  input  logic [HOLD_W-1:0] hold_cnt,
  output state_t            nxt_state,
  output logic              nxt_ptr,
  output logic [HOLD_W-1:0] nxt_hold
);
  logic cur, both, keep, win;
  // win: 1 selects m1; keep: locked owner stays while its hold budget lasts
  always_comb begin
    cur       = state == ST_GNT1;
    both      = &req;
    keep      = both && state != ST_IDLE && lock[cur] && hold_cnt < HOLD_W'(MAX_HOLD - 1);
    win       = !both ? req[1] : state == ST_IDLE ? rr_ptr : keep ? cur : !cur;
    nxt_state = ~|req ? ST_IDLE : win ? ST_GNT1 : ST_GNT0;
    nxt_ptr   = both && !keep ? !win : rr_ptr;
    nxt_hold  = keep ? hold_cnt + 1'b1 : '0;
  end
endmodule

// File: rtl/dram_bus_arbiter.sv
// dram_bus_arbiter: round-robin arbiter sharing one DRAM/MMIO port between CPU (m0) and loader (m1)
// ports: clk, rst_n (async, active low), m0/m1 request channels, bus_* shared port, owner status
module dram_bus_arbiter
  import dram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  dram_bus_arbiter_if.slave   m0,
  dram_bus_arbiter_if.slave   m1,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic                bus_we,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic [1:0]          owner
);
  state_t            state, nxt_state;
  logic              rr_ptr, nxt_ptr, a0, a1;
  logic [HOLD_W-1:0] hold_cnt, nxt_hold;
  dram_bus_arbiter_rr_arb2 #(.MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) u_arb (
    .req      ({m1.req, m0.req}),
    .lock     ({m1.lock, m0.lock}),
    .state    (state),
    .rr_ptr   (rr_ptr),
    .hold_cnt (hold_cnt),
    .nxt_state(nxt_state),
    .nxt_ptr  (nxt_ptr),
    .nxt_hold (nxt_hold)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      state    <= nxt_state;
      rr_ptr   <= nxt_ptr;
      hold_cnt <= nxt_hold;
    end
  // outputs depend only on registered state, so async reset clears them at once
  always_comb begin
    a0        = state == ST_GNT0 && m0.req;
    a1        = state == ST_GNT1 && m1.req;
    m0.ack    = a0;
    m1.ack    = a1;
    m0.rdata  = a0 ? bus_rdata : '0;
    m1.rdata  = a1 ? bus_rdata : '0;
    bus_we    = (a0 & m0.we) | (a1 & m1.we);
    bus_addr  = state == ST_GNT0 ? m0.addr : state == ST_GNT1 ? m1.addr : '0;
    bus_wdata = state == ST_GNT0 ? m0.wdata : state == ST_GNT1 ? m1.wdata : '0;
    owner     = state;
  end
endmodule

// File: tb/tb_dram_bus_arbiter.sv
// tb_dram_bus_arbiter: directed and random checks of dram_bus_arbiter against a behavioural model
module tb_dram_bus_arbiter;
  localparam int AW = 32, DW = 32, MH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  dram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0 ();
  dram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1 ();
  logic [AW-1:0] bus_addr;
  logic          bus_we;
  logic [DW-1:0] bus_wdata, bus_rdata;
  logic [1:0]    owner;
  dram_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH), .HOLD_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .m0(m0), .m1(m1), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .owner(owner)
  );
  int vectors = 0, miscompares = 0;
  int own = 0, fav = 0, streak = 0;
  int acks0 = 0, acks1 = 0, wes = 0;
  logic last0 = 1'b0, last1 = 1'b0;
  int ack_log[$];
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model();
    int r0 = int'(m0.req), r1 = int'(m1.req), cur;
    logic lk;
    if (r0 == 0 && r1 == 0) begin
      own = 0; streak = 0;
    end else if (r0 + r1 == 1) begin
      own = r0 == 1 ? 1 : 2; streak = 0;
    end else if (own == 0) begin
      own = fav + 1; fav = 1 - fav; streak = 0;
    end else begin
      cur = own - 1;
      lk = cur == 0 ? m0.lock : m1.lock;
      if (lk && streak + 1 < MH) streak++;
      else begin fav = cur; own = 2 - cur; streak = 0; end
    end
  endtask
  task automatic step();
    logic e0, e1;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    e0 = own == 1 && m0.req;
    e1 = own == 2 && m1.req;
    ea = own == 1 ? m0.addr : own == 2 ? m1.addr : '0;
    ed = own == 1 ? m0.wdata : own == 2 ? m1.wdata : '0;
    check("m0_ack", 64'(m0.ack), 64'(e0));
    check("m1_ack", 64'(m1.ack), 64'(e1));
    check("bus_we", 64'(bus_we), 64'((e0 & m0.we) | (e1 & m1.we)));
    check("bus_addr", 64'(bus_addr), 64'(ea));
    check("bus_wdata", 64'(bus_wdata), 64'(ed));
    check("m0_rdata", 64'(m0.rdata), e0 ? 64'(bus_rdata) : 64'd0);
    check("m1_rdata", 64'(m1.rdata), e1 ? 64'(bus_rdata) : 64'd0);
    check("owner", 64'(owner), 64'(own));
    acks0 += int'(m0.ack);
    acks1 += int'(m1.ack);
    wes += int'(bus_we);
    last0 = m0.ack;
    last1 = m1.ack;
    if (m0.ack) ack_log.push_back(1);
    if (m1.ack) ack_log.push_back(2);
    @(posedge clk);
    model();
    #1;
  endtask
  task automatic drv0(input logic r, w, l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0.req = r; m0.we = w; m0.lock = l; m0.addr = a; m0.wdata = d;
  endtask
  task automatic drv1(input logic r, w, l, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1.req = r; m1.we = w; m1.lock = l; m1.addr = a; m1.wdata = d;
  endtask
  initial begin
    int exp_seq[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    drv0(0, 0, 0, '0, '0);
    drv1(0, 0, 0, '0, '0);
    bus_rdata = '0;
    #1;
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_bus_we", 64'(bus_we), 64'd0);
    check("rst_acks", 64'({m0.ack, m1.ack}), 64'd0);
    check("rst_bus_addr", 64'(bus_addr), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    // single m0 read, 1-cycle arbitration from idle
    bus_rdata = 32'hDEADBEEF;
    drv0(1, 0, 0, 32'h10, '0);
    step(); step();
    drv0(0, 0, 0, '0, '0);
    step(); step();
    // simultaneous writes alternate, one write strobe per ack
    acks0 = 0; acks1 = 0; wes = 0;
    drv0(1, 1, 0, 32'h100, 32'h11);
    drv1(1, 1, 0, 32'h200, 32'h22);
    repeat (7) step();
    check("alt_acks0", 64'(acks0), 64'd3);
    check("alt_acks1", 64'(acks1), 64'd3);
    check("we_per_ack", 64'(wes), 64'(acks0 + acks1));
    drv0(0, 0, 0, '0, '0);
    drv1(0, 0, 0, '0, '0);
    step(); step();
    // locked m1 against waiting m0: MAX_HOLD beats then one forced m0 beat
    drv1(1, 1, 1, 32'h300, 32'h33);
    step(); step();
    ack_log.delete();
    drv0(1, 0, 0, 32'h40, '0);
    repeat (10) step();
    for (int i = 0; i < 10; i++)
      check($sformatf("lock_seq%0d", i), i < ack_log.size() ? 64'(ack_log[i]) : 64'hFF, 64'(exp_seq[i]));
    drv0(0, 0, 0, '0, '0);
    drv1(0, 0, 0, '0, '0);
    step(); step();
    // owner drops req: no ack, no write, back to idle, regrant after one cycle
    drv0(1, 0, 0, 32'h50, '0);
    step(); step();
    drv0(0, 1, 0, 32'h50, 32'h55);
    step(); step();
    drv0(1, 1, 0, 32'h50, 32'h55);
    step(); step();
    drv0(0, 0, 0, '0, '0);
    step();
    // asynchronous reset in the middle of an m1 write
    drv1(1, 1, 0, 32'hFFFFF060, 32'h66);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_bus_we", 64'(bus_we), 64'd0);
    check("arst_m1_ack", 64'(m1.ack), 64'd0);
    check("arst_owner", 64'(owner), 64'd0);
    own = 0; fav = 0; streak = 0;
    drv1(0, 0, 0, '0, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); model(); #1;
    drv0(1, 0, 0, 32'h70, '0);
    drv1(1, 0, 0, 32'h80, '0);
    step(); step();
    check("post_rst_m0_first", 64'(last0), 64'd1);
    drv0(0, 0, 0, '0, '0);
    drv1(0, 0, 0, '0, '0);
    step(); step();
    // locked m0 with m1 idle keeps the bus indefinitely
    drv0(1, 1, 1, 32'h90, 32'h99);
    step();
    acks0 = 0;
    repeat (20) step();
    check("lock_alone_acks", 64'(acks0), 64'd20);
    drv0(0, 0, 0, '0, '0);
    step();
    // random traffic; a pending request holds its fields until acked
    for (int n = 0; n < 300; n++) begin
      bus_rdata = $urandom;
      if (!m0.req || last0)
        drv0($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      if (!m1.req || last1)
        drv1($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dram_bus_arbiter.md
Name: dram_bus_arbiter

Overview:
- Two-master arbiter in front of dram_interface; shares its single data-memory/MMIO port between the CPU data path (m0) and the debug/program loader (m1).
- Single-beat transactions with a req/ack handshake and round-robin fairness.
- Optional lock lets a master hold the bus for bursts, bounded by a hold counter.
- The shared-port read data is combinational from the memory, so an access completes in the cycle it is granted.

Parameters:
- ADDR_W, 32, address width of masters and shared port
- DATA_W, 32, data width
- MAX_HOLD, 8, max consecutive locked beats while the other master waits (>=1)
- HOLD_W, 4, hold counter width (must satisfy 2^HOLD_W > MAX_HOLD)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- m0_req  in  1  CPU requests a beat
- m0_we  in  1  CPU beat is a write
- m0_lock  in  1  CPU requests to keep ownership
- m0_addr  in  ADDR_W  CPU address
- m0_wdata  in  DATA_W  CPU write data
- m0_ack  out  1  CPU beat completes this cycle
- m0_rdata  out  DATA_W  read data to CPU
- m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_ack, m1_rdata: same as m0_* for the loader
- bus_addr  out  ADDR_W  to dram_interface addra
- bus_we  out  1  to dram_interface dram_we_wire
- bus_wdata  out  DATA_W  to dram_interface wdata
- bus_rdata  in  DATA_W  from dram_interface rdata
- owner  out  2  00 idle, 01 m0, 10 m1 (debug/status)

Behaviour:
- State register: IDLE, GNT0, GNT1; encoding matches `owner`. Also rr_ptr (1 bit, 0 = m0 favoured) and hold_cnt (HOLD_W).
- Reset (async, rst_n=0): state IDLE, rr_ptr 0, hold_cnt 0. All outputs 0: acks, bus_we, bus_addr, bus_wdata, m*_rdata, owner.
- Bus mux is combinational from the registered state.
  - GNTx: bus_addr/bus_wdata = mx_addr/mx_wdata; bus_we = mx_we & mx_req.
  - IDLE: bus drives zeros.
- Handshake:
  - mx_ack = (state==GNTx) & mx_req.
  - mx_rdata = bus_rdata when mx_ack, else 0.
  - Each cycle with ack=1 is exactly one beat; a write commits at the clock edge ending that cycle.
  - A master holds req/we/addr/wdata stable until ack, and may keep req high for back-to-back beats.
- Latency:
  - From IDLE: req sampled at edge N, ack in cycle N+1 (1-cycle arbitration).
  - While owner: ack in the same cycle.
- Next state, evaluated every edge:
  - No req: IDLE; hold_cnt 0.
  - Exactly one req: grant it; rr_ptr unchanged.
  - Both req, state IDLE: grant master selected by rr_ptr.
  - Both req, owner x with lock_x=0: grant other; rr_ptr points past new owner.
  - Both req, owner x with lock_x=1 and hold_cnt < MAX_HOLD-1: keep x; hold_cnt+1.
  - Both req, owner x with lock_x=1 and hold_cnt == MAX_HOLD-1: forced switch to other; hold_cnt 0.
  - hold_cnt clears on any ownership change and whenever the other master is not requesting.
- Owner drops req while granted: ack 0 and bus_we 0 that cycle (no spurious write); re-arbitrates at the next edge.
- Locked owner with the other master idle: stays owner indefinitely; counter not advanced.
- A master's req/addr changing before its ack is a protocol violation; the arbiter gives no guarantee in that case.
- rst_n asserted mid-beat: bus_we drops immediately (asynchronous); the write is not committed; no ack.
- CPU stall: the core stalls its PC on m0_req & ~m0_ack (integration rule, outside this block).

Decomposition:
- Shared include bus_defs.vh (team package): state/owner encodings ST_IDLE=2'b00, ST_GNT0=2'b01, ST_GNT1=2'b10; default ADDR_W/DATA_W.
- One sub-module, rr_arb2: pure combinational next-owner/next-ptr/next-hold logic from {req, lock, state, rr_ptr, hold_cnt}.
- The top level holds the registers, bus mux and ack logic.

Test Plan:
- Reset, then m0 read of 0x00000010 with bus_rdata=0xDEADBEEF → owner 01 from next cycle; m0_ack=1, m0_rdata=0xDEADBEEF; bus_we=0.
- m0 and m1 writes to 0x100/0x200 (data 0x11/0x22) raised together from IDLE after reset → m0 granted first, then m1. The beats alternate while both remain requesting; exactly one bus_we pulse per ack.
- MAX_HOLD=4; m1 locked with continuous req, m0 req held → m1 gets 4 consecutive acks, then m0 gets 1, then m1 resumes.
- m0 owner drops req for one cycle while m1 idle → m0_ack=0, bus_we=0 that cycle; state IDLE next edge; m0 regranted with 1-cycle latency.
- rst_n pulsed low mid-cycle during m1 write to 0xFFFFF060 → bus_we, m1_ack, owner go 0 immediately; after release, IDLE with rr_ptr favouring m0.
- Locked m0 with m1 idle for 20 beats → 20 consecutive acks; hold_cnt stays 0; no forced switch.
